// File: rtl/shift_univ_if.sv
// Bundles the control, data and status signals of the universal shift register.
// The master drives the operation controls; the slave (the shifter) drives the results.
interface shift_univ_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] pd;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CNT_W-1:0] cnt;
  logic             zero;

  modport master (output en, mode, sin, pd, input q, sout, cnt, zero);
  modport slave  (input en, mode, sin, pd, output q, sout, cnt, zero);
endinterface

// File: rtl/shift_univ.sv
// Universal shift register: hold, shift, rotate, arithmetic shift, load and clear,
// with a serial-out bit, a shift-operation counter and a combinational zero flag.
module shift_univ #(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        ck,
  input  logic        res,
  shift_univ_if.slave bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [CNT_W-1:0] r_cnt;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift;

  assign w_mode = mode_e'(bus.mode);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cnt_nxt  = r_cnt;
    w_shift    = 1'b0;
    case (w_mode)
      M_HOLD: ;
      M_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], bus.sin};
        w_sout_nxt = r_q[WIDTH-1];
        w_shift    = 1'b1;
      end
      M_SHR: begin
        w_q_nxt    = {bus.sin, r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_shift    = 1'b1;
      end
      M_ROL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout_nxt = r_q[WIDTH-1];
        w_shift    = 1'b1;
      end
      M_ROR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_shift    = 1'b1;
      end
      M_LOAD: begin
        w_q_nxt    = bus.pd;
        w_sout_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
      M_ASR: begin
        w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_shift    = 1'b1;
      end
      M_CLR: begin
        w_q_nxt    = RESET_VAL;
        w_sout_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
    endcase
    // Counter wraps naturally at all-ones.
    if (w_shift) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Reset wins over enable, enable wins over mode.
  always_ff @(posedge ck) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!res) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_cnt  <= '0;
    end else if (bus.en) begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.q    = r_q;
  assign bus.sout = r_sout;
  assign bus.cnt  = r_cnt;
  assign bus.zero = (r_q == '0);

endmodule

// File: doc/shift_univ.md
Name: shift_univ

Overview:
- Parametrised universal shift register, the next generation of the team's 4-bit serial-in shifter.
- Adds configurable width and multiple operating modes: hold, shift left/right, rotate left/right, parallel load, arithmetic shift right, and clear.
- Adds a shifted-out serial bit, a shift-operation counter and a zero flag.
- Used as a general data-path shifter and as a serial/parallel converter in student lab designs.

Parameters:
- WIDTH, 4, register width in bits (legal range 2 to 32).
- CNT_W, 4, width of the shift-operation counter.
- RESET_VAL, 0, value loaded into q on reset and on mode CLR (WIDTH bits).

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- res  input  1  synchronous reset, active-low; sampled on the rising edge of ck.
- en  input  1  operation enable; when 0, all state holds regardless of mode.
- mode  input  3  operation select (encoding below).
- sin  input  1  serial input bit for the SHL and SHR modes.
- pd  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents, registered.
- sout  output  1  bit shifted or rotated out by the most recent shift-class operation, registered.
- cnt  output  CNT_W  number of shift-class operations since the last reset/LOAD/CLR, registered.
- zero  output  1  combinational, 1 when q == 0.

Behaviour:
- Reset: when res == 0 at a rising edge of ck:
  - q <= RESET_VAL, sout <= 0, cnt <= 0.
  - Reset overrides en and mode.
  - Reset mid-sequence discards all prior state; there is no asynchronous path.
- When res == 1 and en == 0: q, sout and cnt all hold.
- When res == 1 and en == 1, mode encoding (N = WIDTH-1):
  - 000 HOLD: q, sout and cnt hold.
  - 001 SHL: q <= {q[N-1:0], sin}; sout <= q[N].
  - 010 SHR: q <= {sin, q[N:1]}; sout <= q[0].
  - 011 ROL: q <= {q[N-1:0], q[N]}; sout <= q[N].
  - 100 ROR: q <= {q[0], q[N:1]}; sout <= q[0].
  - 101 LOAD: q <= pd; sout <= 0; cnt <= 0.
  - 110 ASR: q <= {q[N], q[N:1]} (sign preserved); sout <= q[0].
  - 111 CLR: q <= RESET_VAL; sout <= 0; cnt <= 0.
- Shift-class modes are SHL, SHR, ROL, ROR and ASR. Each of these increments cnt by 1 per enabled cycle.
- cnt wraps modulo 2^CNT_W (all-ones -> 0) with no saturation and no flag.
- Latency: exactly one ck cycle from sampled inputs to updated q, sout and cnt. zero follows q combinationally in the same cycle.
- Inputs are sampled only on the rising edge. Changes to sin, pd or mode between edges have no effect.
- sin is ignored in every mode except SHL and SHR. pd is ignored except in LOAD.
- Simultaneous events, in priority order: reset > en == 0 > mode.
- Mode may change every cycle with no bubble. For example, LOAD followed by SHL on the next edge shifts the freshly loaded value.
- Every case of mode is covered, including 000. No latches; no X may reach q when the inputs are known.
- Expected RTL size: 120–250 lines.

Test Plan (WIDTH=4, CNT_W=4, RESET_VAL=0 unless stated):
- Reset: hold res=0 for one edge with en=1, mode=101, pd=1010 -> q=0000, sout=0, cnt=0, zero=1. Release res=1 -> the next edge loads 1010.
- Serial-in SHL: from q=0000, en=1, mode=001, apply sin=1,0,1,1 on four edges -> q=0001, 0010, 0101, 1011; cnt=4; sout=0 on every edge.
- Rotate/ASR: LOAD 1001, then ROR -> q=1100, sout=1. Then ASR -> q=1110, sout=0. Then ROL -> q=1101, sout=1. cnt=3 after these.
- Enable and hold: with q=0110, en=0 and mode=001 for three edges -> q=0110, cnt unchanged. mode=000 with en=1 -> also unchanged.
- Counter wrap: 16 consecutive SHR edges with sin=0 after LOAD -> cnt=0 after the 16th edge; q=0000, zero=1.
- Priority and mid-operation reset: during a SHL burst with cnt=5, drive res=0 and en=0 on the same edge -> q=0000, cnt=0, sout=0. Separately, WIDTH=8 and RESET_VAL=8'hA5 with mode=111 -> q=A5, cnt=0.
